// File: rtl/pipeline_wb_gen.sv
// Writeback stage: holds one instruction, selects ALU result or extracted load data,
// and handshakes the register-file write port. Also carries the delayed-B register pair.
module pipeline_wb_gen #(
  parameter int unsigned DW      = 16,
  parameter int unsigned RW      = 3,
  parameter logic [2:0]  LDR_OPC = 3'b011
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic          in_wen,
  input  logic [RW-1:0] in_wnum,
  input  logic [DW-1:0] in_result,
  input  logic [1:0]    in_ldmode,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] db_data_in,
  input  logic          db_valid_in,
  input  logic          fetch_next,
  output logic [DW-1:0] db_data_out,
  output logic          db_valid_out,
  output logic          wb_valid,
  output logic [RW-1:0] wb_num,
  output logic [DW-1:0] wb_data,
  input  logic          wb_ack
);

  logic          s_valid_q;
  logic [2:0]    s_opcode_q;
  logic          s_wen_q;
  logic [RW-1:0] s_wnum_q;
  logic [DW-1:0] s_result_q;
  logic [1:0]    s_ldmode_q;
  logic          fresh_q;
  logic [DW-1:0] rdata_hold_q;
  logic [DW-1:0] db_data_q;
  logic          db_valid_q;

  logic          commit;
  logic          accept;
  logic [DW-1:0] memdata;
  logic [DW-1:0] ext;

  // A non-writing entry retires without waiting for the write port.
  assign commit   = s_valid_q && (!s_wen_q || wb_ack);
  assign in_ready = !rst && (!s_valid_q || commit);
  assign accept   = in_valid && in_ready;

  // The sync RAM only presents data in the cycle right after acceptance.
  assign memdata  = fresh_q ? mem_rdata : rdata_hold_q;

  always_comb begin
    ext = memdata;
    case (s_ldmode_q)
      2'b00:   ext = memdata;
      2'b01:   ext = {{(DW-8){1'b0}}, memdata[7:0]};
      2'b10:   ext = {{(DW-8){memdata[7]}}, memdata[7:0]};
      default: ext = memdata >> 8;
    endcase
  end

  assign wb_valid     = s_valid_q && s_wen_q;
  assign wb_num       = s_wnum_q;
  assign wb_data      = (s_opcode_q == LDR_OPC) ? ext : s_result_q;
  assign db_data_out  = db_data_q;
  assign db_valid_out = db_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_q    <= 1'b0;
      s_opcode_q   <= '0;
      s_wen_q      <= 1'b0;
      s_wnum_q     <= '0;
      s_result_q   <= '0;
      s_ldmode_q   <= '0;
      fresh_q      <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      fresh_q <= accept;
      if (fresh_q && !commit) begin
        rdata_hold_q <= mem_rdata;
      end
      if (accept) begin
        s_valid_q  <= 1'b1;
        s_opcode_q <= in_opcode;
        s_wen_q    <= in_wen;
        s_wnum_q   <= in_wnum;
        s_result_q <= in_result;
        s_ldmode_q <= in_ldmode;
      end else if (commit) begin
        s_valid_q <= 1'b0;
      end
    end
  end

  // Delayed-B pair runs independently of the writeback entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_data_q  <= '0;
      db_valid_q <= 1'b0;
    end else if (fetch_next || !db_valid_q) begin
      db_data_q  <= db_data_in;
      db_valid_q <= db_valid_in;
    end
  end

endmodule

// File: tb/tb_pipeline_wb_gen.sv
// Self-checking bench for pipeline_wb_gen: directed stimulus with a write scoreboard
// checked whenever the DUT completes a register-file write.
module tb_pipeline_wb_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic          in_wen;
  logic [RW-1:0] in_wnum;
  logic [DW-1:0] in_result;
  logic [1:0]    in_ldmode;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] db_data_in;
  logic          db_valid_in;
  logic          fetch_next;
  logic [DW-1:0] db_data_out;
  logic          db_valid_out;
  logic          wb_valid;
  logic [RW-1:0] wb_num;
  logic [DW-1:0] wb_data;
  logic          wb_ack;

  typedef struct packed {
    logic [RW-1:0] num;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  pipeline_wb_gen #(.DW(DW), .RW(RW), .LDR_OPC(3'b011)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_wen       (in_wen),
    .in_wnum      (in_wnum),
    .in_result    (in_result),
    .in_ldmode    (in_ldmode),
    .mem_rdata    (mem_rdata),
    .db_data_in   (db_data_in),
    .db_valid_in  (db_valid_in),
    .fetch_next   (fetch_next),
    .db_data_out  (db_data_out),
    .db_valid_out (db_valid_out),
    .wb_valid     (wb_valid),
    .wb_num       (wb_num),
    .wb_data      (wb_data),
    .wb_ack       (wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 unit after the rising edge; checks happen 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic push(input logic [RW-1:0] num, input logic [DW-1:0] data);
    wr_t w;
    w.num  = num;
    w.data = data;
    sb_q.push_back(w);
  endtask

  task automatic drive(input logic v, input logic [2:0] opc, input logic wen,
                       input logic [RW-1:0] num, input logic [DW-1:0] res,
                       input logic [1:0] mode);
    in_valid  = v;
    in_opcode = opc;
    in_wen    = wen;
    in_wnum   = num;
    in_result = res;
    in_ldmode = mode;
  endtask

  // Every completed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_valid && wb_ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", 32'(wb_num), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("sb_wb_num", 32'(wb_num), 32'(e.num));
        check("sb_wb_data", 32'(wb_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    modes [3];
    logic [DW-1:0] exts  [3];
    modes[0] = 2'b01; exts[0] = 16'h00F0;
    modes[1] = 2'b10; exts[1] = 16'hFFF0;
    modes[2] = 2'b11; exts[2] = 16'h0012;

    rst = 1'b1;
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    mem_rdata   = '0;
    db_data_in  = 16'h5A5A;
    db_valid_in = 1'b1;
    fetch_next  = 1'b0;
    wb_ack      = 1'b0;
    step();
    step();
    settle();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_db_valid", 32'(db_valid_out), 32'd0);
    check("rst_db_data", 32'(db_data_out), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    db_valid_in = 1'b0;
    db_data_in  = '0;
    rst         = 1'b0;
    step();
    settle();
    check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("post_rst_db_valid", 32'(db_valid_out), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back ALU writes with the port always granted.
    wb_ack = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 3'd2, 16'h1234, 2'b00);
    push(3'd2, 16'h1234);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd3, 16'h5678, 2'b00);
    push(3'd3, 16'h5678);
    settle();
    check("b2b_wb_valid0", 32'(wb_valid), 32'd1);
    check("b2b_wb_data0", 32'(wb_data), 32'h1234);
    check("b2b_in_ready0", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    settle();
    check("b2b_wb_num1", 32'(wb_num), 32'd3);
    check("b2b_wb_data1", 32'(wb_data), 32'h5678);
    check("b2b_in_ready1", 32'(in_ready), 32'd1);
    step();
    settle();
    check("b2b_drain_wb_valid", 32'(wb_valid), 32'd0);

    // Stalled load: memory data vanishes after one cycle, write held until ack.
    wb_ack = 1'b0;
    drive(1'b1, 3'b011, 1'b1, 3'd5, 16'hAAAA, 2'b00);
    push(3'd5, 16'hBEEF);
    step();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    mem_rdata = 16'hBEEF;
    settle();
    check("stall_wb_valid", 32'(wb_valid), 32'd1);
    check("stall_wb_data_fresh", 32'(wb_data), 32'hBEEF);
    check("stall_in_ready_fresh", 32'(in_ready), 32'd0);
    step();
    mem_rdata = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("stall_wb_data_held", 32'(wb_data), 32'hBEEF);
      check("stall_in_ready_held", 32'(in_ready), 32'd0);
      step();
    end
    wb_ack = 1'b1;
    settle();
    check("stall_ack_in_ready", 32'(in_ready), 32'd1);
    check("stall_ack_wb_data", 32'(wb_data), 32'hBEEF);
    step();
    settle();
    check("stall_done_wb_valid", 32'(wb_valid), 32'd0);

    // Load extraction modes.
    for (int m = 0; m < 3; m++) begin
      drive(1'b1, 3'b011, 1'b1, 3'(m + 1), 16'h7777, modes[m]);
      push(3'(m + 1), exts[m]);
      step();
      drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
      mem_rdata = 16'h12F0;
      settle();
      check("ext_wb_data", 32'(wb_data), 32'(exts[m]));
      step();
      mem_rdata = '0;
    end

    // ldmode must not affect an ALU result.
    drive(1'b1, 3'd2, 1'b1, 3'd4, 16'hABCD, 2'b01);
    push(3'd4, 16'hABCD);
    step();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    mem_rdata = 16'h12F0;
    settle();
    check("alu_ignore_ldmode", 32'(wb_data), 32'hABCD);
    step();
    mem_rdata = '0;

    // Back-to-back loads: each uses the memory data of its own fresh cycle.
    drive(1'b1, 3'b011, 1'b1, 3'd1, '0, 2'b00);
    push(3'd1, 16'hA5A5);
    step();
    drive(1'b1, 3'b011, 1'b1, 3'd2, '0, 2'b10);
    push(3'd2, 16'hFF85);
    mem_rdata = 16'hA5A5;
    settle();
    check("b2b_ld0_wb_data", 32'(wb_data), 32'hA5A5);
    step();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    mem_rdata = 16'h3C85;
    settle();
    check("b2b_ld1_wb_data", 32'(wb_data), 32'hFF85);
    step();
    mem_rdata = '0;

    // Non-writing instruction retires without ack and does not block the next one.
    wb_ack = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 3'd7, 16'h1111, 2'b00);
    step();
    drive(1'b1, 3'd0, 1'b1, 3'd1, 16'h4242, 2'b00);
    settle();
    check("nowr_wb_valid", 32'(wb_valid), 32'd0);
    check("nowr_in_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    settle();
    check("nowr_next_wb_valid", 32'(wb_valid), 32'd1);
    check("nowr_next_wb_num", 32'(wb_num), 32'd1);
    check("nowr_next_in_ready", 32'(in_ready), 32'd0);
    step();
    wb_ack = 1'b1;
    push(3'd1, 16'h4242);
    step();
    wb_ack = 1'b0;

    // Delayed-B hold and advance.
    db_data_in  = 16'h1111;
    db_valid_in = 1'b1;
    step();
    db_data_in = 16'h2222;
    settle();
    check("db_load_valid", 32'(db_valid_out), 32'd1);
    check("db_load_data", 32'(db_data_out), 32'h1111);
    step();
    settle();
    check("db_hold_data", 32'(db_data_out), 32'h1111);
    step();
    fetch_next = 1'b1;
    settle();
    check("db_hold2_data", 32'(db_data_out), 32'h1111);
    step();
    fetch_next  = 1'b0;
    db_data_in  = 16'h3333;
    db_valid_in = 1'b0;
    settle();
    check("db_adv_data", 32'(db_data_out), 32'h2222);
    step();
    fetch_next = 1'b1;
    settle();
    check("db_hold3_data", 32'(db_data_out), 32'h2222);
    step();
    fetch_next = 1'b0;
    settle();
    check("db_adv2_valid", 32'(db_valid_out), 32'd0);
    check("db_adv2_data", 32'(db_data_out), 32'h3333);

    // Reset during a stalled write discards it.
    drive(1'b1, 3'd0, 1'b1, 3'd6, 16'h6666, 2'b00);
    step();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 2'b00);
    settle();
    check("rststall_wb_valid", 32'(wb_valid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    wb_ack = 1'b1;
    settle();
    check("rststall_after_wb_valid", 32'(wb_valid), 32'd0);
    step();
    step();
    settle();
    check("rststall_late_wb_valid", 32'(wb_valid), 32'd0);
    wb_ack = 1'b0;
    step();

    check("sb_outstanding", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
